// File: rtl/prakh_test_pkg.sv
// Shared types and constants for the prakh pattern engine.
package prakh_test_pkg;

  // Operating modes, encoded as they appear in ui_in.
  typedef enum logic [1:0] {
    MODE_COUNT    = 2'b00,
    MODE_PRBS     = 2'b01,
    MODE_CHECK    = 2'b10,
    MODE_READBACK = 2'b11
  } mode_e;

  // Engine control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Status bit positions in uo_out, counted down from the MSB.
  localparam int UO_BUSY_OFS = 0;
  localparam int UO_DONE_OFS = 1;
  localparam int UO_ERR_OFS  = 2;

  // Default Galois tap mask and start value for the 8-bit LFSR.
  localparam logic [7:0] DEF_POLY = 8'hB8;
  localparam logic [7:0] DEF_SEED = 8'h01;

endpackage

// File: rtl/prakh_lfsr.sv
// Galois right-shift LFSR shared by the PRBS generator and the checker.
module prakh_lfsr
  import prakh_test_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  // One Galois step: shift right, fold the taps back in when a 1 falls out.
  assign nxt = (q >> 1) ^ (q[0] ? POLY : '0);

  // Register: load restarts the sequence and wins over advance.
  always_ff @(posedge clk) begin
    if (!rst_n)    q <= SEED;
    else if (load) q <= SEED;
    else if (adv)  q <= nxt;
  end

endmodule

// File: rtl/prakh_pattern_engine.sv
// Built-in test engine: counter/PRBS burst generator, PRBS checker and
// error-count readback, all driven from ui_in with registered outputs.
module prakh_pattern_engine
  import prakh_test_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                LEN_W     = 5,
  parameter int                CNT_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEF_POLY),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] ui_in,
  input  logic [DATA_W-1:0] uio_in,
  output logic [DATA_W-1:0] uo_out,
  output logic [DATA_W-1:0] uio_out,
  output logic [DATA_W-1:0] uio_oe
);

  localparam int              BEAT_W  = DATA_W - 3;
  localparam int              NSLICE  = CNT_W / DATA_W;
  localparam logic [BEAT_W-1:0] RB_LAST = BEAT_W'(NSLICE - 1);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d, m_sel;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, b_sel, last_beat;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic                start_q, start_det;
  logic [DATA_W-1:0]   uo_d, uio_out_d, uio_oe_d, prbs_sel;
  logic [DATA_W-1:0]   lfsr_q, lfsr_nxt;
  logic                lfsr_load, lfsr_adv, emit;

  // Error counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // One DATA_W-wide slice of the error counter, LS slice at index 0.
  function automatic logic [DATA_W-1:0] rb_slice(input logic [CNT_W-1:0] v,
                                                 input logic [BEAT_W-1:0] idx);
    return v[32'(idx) * DATA_W +: DATA_W];
  endfunction

  assign start_det = !start_q && ui_in[DATA_W-1] &&
                     (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_beat = (mode_q == MODE_READBACK) ? RB_LAST : BEAT_W'(len_q);

  prakh_lfsr #(
    .WIDTH (DATA_W),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load & ena),
    .adv   (lfsr_adv & ena),
    .q     (lfsr_q),
    .nxt   (lfsr_nxt)
  );

  // Next-state, counter and output-word selection for the burst FSM.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    uio_out_d = uio_out;
    uio_oe_d  = uio_oe;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    emit      = 1'b0;
    m_sel     = mode_q;
    b_sel     = '0;
    prbs_sel  = LFSR_SEED;

    if (start_det) begin
      mode_d    = mode_e'(ui_in[DATA_W-2:DATA_W-3]);
      len_d     = ui_in[LEN_W-1:0];
      beat_d    = '0;
      state_d   = ST_RUN;
      lfsr_load = 1'b1;
      if (mode_d == MODE_CHECK) begin
        cnt_d    = '0;
        sticky_d = 1'b0;
      end
      emit     = 1'b1;
      m_sel    = mode_d;
      b_sel    = '0;
      prbs_sel = LFSR_SEED;
    end else if (state_q == ST_RUN) begin
      lfsr_adv = (mode_q == MODE_PRBS) || (mode_q == MODE_CHECK);
      if (mode_q == MODE_CHECK && uio_in != lfsr_q) begin
        cnt_d    = sat_inc(cnt_q);
        sticky_d = 1'b1;
      end
      if (beat_q == last_beat) begin
        state_d   = ST_DONE;
        beat_d    = '0;
        uio_out_d = '0;
        uio_oe_d  = '0;
      end else begin
        beat_d   = beat_q + 1'b1;
        emit     = 1'b1;
        b_sel    = beat_d;
        prbs_sel = lfsr_nxt;
      end
    end

    if (emit) begin
      case (m_sel)
        MODE_COUNT:    begin uio_out_d = DATA_W'(b_sel);        uio_oe_d = '1; end
        MODE_PRBS:     begin uio_out_d = prbs_sel;              uio_oe_d = '1; end
        MODE_READBACK: begin uio_out_d = rb_slice(cnt_q, b_sel); uio_oe_d = '1; end
        default:       begin uio_out_d = '0;                    uio_oe_d = '0; end
      endcase
    end

    uo_d                          = '0;
    uo_d[DATA_W-1-UO_BUSY_OFS]    = (state_d == ST_RUN);
    uo_d[DATA_W-1-UO_DONE_OFS]    = (state_d == ST_DONE);
    uo_d[DATA_W-1-UO_ERR_OFS]     = sticky_d;
    uo_d[BEAT_W-1:0]              = beat_d;
  end

  // State and output registers; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COUNT;
      len_q    <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      start_q  <= 1'b0;
      uo_out   <= '0;
      uio_out  <= '0;
      uio_oe   <= '0;
    end else if (ena) begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      start_q  <= ui_in[DATA_W-1];
      uo_out   <= uo_d;
      uio_out  <= uio_out_d;
      uio_oe   <= uio_oe_d;
    end
  end

endmodule

// File: tb/tb_prakh_pattern_engine.sv
// Randomized self-checking bench for prakh_pattern_engine.
module tb_prakh_pattern_engine;

  logic       clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: error count and sticky flag as plain integers.
  int         m_cnt    = 0;
  logic       m_sticky = 1'b0;
  logic [7:0] din [0:31];

  prakh_pattern_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // PRBS value after k steps from the seed.
  function automatic logic [7:0] prbs_at(input int k);
    logic [7:0] x = 8'h01;
    for (int i = 0; i < k; i++) x = (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    return x;
  endfunction

  // One full burst: start, every beat, optional ena stalls and start noise, DONE.
  task automatic run(input int mode, input int len, input int stall_pct);
    int nb;
    logic [7:0] eo, eoe, euo, save_ui;
    ui_in = 8'h00;
    tick;
    ui_in = {1'b1, 2'(mode), 5'(len)};
    tick;
    if (mode == 2) begin m_cnt = 0; m_sticky = 1'b0; end
    nb = (mode == 3) ? 2 : len + 1;
    for (int k = 0; k < nb; k++) begin
      case (mode)
        0:       eo = 8'(k);
        1:       eo = prbs_at(k);
        3:       eo = 8'((m_cnt >> (8 * k)) & 255);
        default: eo = 8'h00;
      endcase
      eoe = (mode == 2) ? 8'h00 : 8'hFF;
      euo = {1'b1, 1'b0, m_sticky, 5'(k)};
      check($sformatf("m%0d_b%0d_uio", mode, k), uio_out, eo);
      check($sformatf("m%0d_b%0d_oe", mode, k), uio_oe, eoe);
      check($sformatf("m%0d_b%0d_uo", mode, k), uo_out, euo);
      uio_in = din[k];
      if ($urandom_range(1) == 1) ui_in = 8'($urandom);
      if ($urandom_range(99) < stall_pct) begin
        save_ui = ui_in;
        ena = 1'b0;
        repeat ($urandom_range(3, 1)) begin
          ui_in  = 8'($urandom);
          uio_in = 8'($urandom);
          tick;
          check("stall_uio", uio_out, eo);
          check("stall_oe", uio_oe, eoe);
          check("stall_uo", uo_out, euo);
        end
        ena    = 1'b1;
        ui_in  = save_ui;
        uio_in = din[k];
      end
      tick;
      if (mode == 2 && din[k] != prbs_at(k)) begin
        if (m_cnt < 65535) m_cnt++;
        m_sticky = 1'b1;
      end
    end
    check($sformatf("m%0d_done_uo", mode), uo_out, {2'b01, m_sticky, 5'd0});
    check($sformatf("m%0d_done_uio", mode), uio_out, 8'h00);
    check($sformatf("m%0d_done_oe", mode), uio_oe, 8'h00);
  endtask

  initial begin
    int mode, len;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    for (int i = 0; i < 32; i++) din[i] = 8'h00;
    tick;
    tick;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    tick;
    check("idle_uo", uo_out, 8'h00);

    // Directed bursts from the basic scenarios.
    run(0, 3, 0);
    run(1, 5, 0);
    din[0] = 8'h01; din[1] = 8'hB8; din[2] = 8'h00;
    din[3] = 8'h2E; din[4] = 8'h17; din[5] = 8'hFF;
    run(2, 5, 0);
    run(3, 0, 0);
    run(0, 6, 60);
    run(0, 0, 0);

    // Randomized bursts with stalls and start-line noise.
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(3);
      len  = $urandom_range(31);
      for (int k = 0; k < 32; k++)
        din[k] = ($urandom_range(3) == 0) ? 8'($urandom) : prbs_at(k);
      run(mode, len, 25);
      if ($urandom_range(2) == 0) run(3, len, 0);
    end

    // Reset in the middle of a PRBS burst.
    ui_in = 8'h00;
    tick;
    ui_in = 8'hA5;
    tick;
    check("mid_b0", uio_out, 8'h01);
    tick;
    check("mid_b1", uio_out, 8'hB8);
    tick;
    check("mid_b2", uio_out, 8'h5C);
    check("mid_b2_uo", uo_out, {2'b10, m_sticky, 5'd2});
    rst_n = 1'b0;
    tick;
    check("mid_rst_uo", uo_out, 8'h00);
    check("mid_rst_uio", uio_out, 8'h00);
    check("mid_rst_oe", uio_oe, 8'h00);
    rst_n    = 1'b1;
    m_cnt    = 0;
    m_sticky = 1'b0;
    run(3, 0, 0);
    run(1, 5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prakh_pattern_engine.md
Name: prakh_pattern_engine

Overview:
- Parametrised built-in test engine for Tiny Tapeout user projects; next generation of the fixed-function prakh test design.
- Generates counter or PRBS bursts on the uio bus, checks a PRBS stream received on uio against a local reference, and reads back a saturating error count.
- Controlled entirely from ui_in; status is reported on uo_out.
- Sits directly under the tt_um_ top and uses the standard TT pin set.

Parameters:
- DATA_W, 8, width of ui/uo/uio buses; must be >= 8.
- LEN_W, 5, width of burst-length field ui_in[LEN_W-1:0]; must be <= DATA_W-3.
- CNT_W, 16, error-counter width; must be a multiple of DATA_W.
- LFSR_POLY, 8'hB8, Galois right-shift tap mask, DATA_W bits.
- LFSR_SEED, 8'h01, LFSR start value; must be nonzero.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  design enable; 0 freezes all state.
- ui_in  in  DATA_W  [DATA_W-1] start; [DATA_W-2:DATA_W-3] mode; [LEN_W-1:0] len.
- uio_in  in  DATA_W  PRBS stream under test (CHECK mode).
- uo_out  out  DATA_W  [DATA_W-1] busy, [DATA_W-2] done, [DATA_W-3] err_sticky, low bits = beat index, zero-extended.
- uio_out  out  DATA_W  generated data or readback.
- uio_oe  out  DATA_W  all 1s while driving; all 0s otherwise.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state IDLE; uo_out, uio_out and uio_oe = 0.
  - lfsr = LFSR_SEED; err_cnt = 0; err_sticky = 0.
  - start_q = 0.
- All outputs are registered.
- ena=0: no register changes, including start_q; outputs hold.
- Start detection: start_q registers ui_in[DATA_W-1]. A start is a 0->1 transition (start_q=0, bit=1) at an edge with ena=1 while in IDLE or DONE.
  - At that edge N: capture mode and len; set beat=0 and lfsr=SEED; enter RUN.
  - The beat-0 output is valid after edge N.
- Start transitions while in RUN are ignored and not queued.
- FSM: IDLE -> RUN on start; RUN -> DONE when the last beat completes; DONE -> RUN on start. No other transitions.
- Modes:
  - 00 COUNT: uio_oe all 1s; uio_out = beat (0,1,...,len); len+1 beats.
  - 01 PRBS: uio_oe all 1s; uio_out = lfsr; advance each RUN edge; len+1 beats.
  - 10 CHECK: uio_oe = 0.
    - err_cnt and err_sticky clear at start edge N.
    - Each RUN edge: compare uio_in with lfsr. On mismatch, err_cnt++ (saturates at 2^CNT_W-1) and err_sticky=1. Then advance lfsr.
    - len+1 compares.
  - 11 READBACK: uio_oe all 1s; uio_out = err_cnt slice [beat*DATA_W +: DATA_W], LS slice first. Beats = CNT_W/DATA_W; len is ignored. err_cnt is unchanged.
- LFSR advance: next = (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0).
- Each RUN edge: if beat == last, go to DONE, set uio_oe=0 and uio_out=0. Otherwise beat++ and output the next value.
- DONE exit edge is N+len+1, or N+CNT_W/DATA_W for READBACK.
- Status bits: busy=1 in RUN only; done=1 in DONE only.
- len=0 gives one beat; DONE at edge N+1.
- err_cnt and err_sticky persist across non-CHECK runs; only reset or a CHECK start clears them.
- Reset mid-RUN: immediate return to the reset state; uio_oe=0 after that edge.

Decomposition:
- Package prakh_test_pkg:
  - mode enum (COUNT, PRBS, CHECK, READBACK) and state enum (IDLE, RUN, DONE).
  - uo_out status bit-position constants.
  - default POLY and SEED constants.
- Sub-module prakh_lfsr:
  - Galois LFSR, parameters WIDTH, POLY, SEED.
  - Inputs load and adv (load wins); output q.
  - Shared by the PRBS and CHECK paths.

Test Plan:
- Reset: rst_n low 2 cycles -> uo_out=0, uio_out=0, uio_oe=00.
- ui_in=0x83 after 0x00 (COUNT, len=3) -> uio_out 00,01,02,03 with uio_oe=FF; busy=1; at edge N+4, uo_out=0x40 and uio_oe=00.
- ui_in=0xA5 (PRBS, len=5) -> uio_out 01,B8,5C,2E,17,B3, then DONE.
- CHECK, len=5, uio_in 01,B8,00,2E,17,FF -> err_cnt=2; err_sticky=1; READBACK (ui_in=0xE0) -> uio_out 02 then 00.
- Start retoggled mid-COUNT; ena=0 for 3 cycles mid-run -> retoggle ignored; outputs freeze; sequence resumes without a skipped beat.
- Reset asserted at beat 2 of PRBS -> next cycle uio_oe=00, state IDLE; new PRBS run restarts at 01.
